square_motion: RTL and testbench
================================

# square_motion

Moves the Pong square across the 640×480 field. Each clock it integrates the horizontal and vertical speeds from the velocity mapper, given in pixels/second, into an on-screen position, and bounces the square off the top and bottom walls. It detects paddle contact and reports it to the velocity mapper as a `paddle_hit` pulse with the offset `hit_y`. It reports out-of-bounds squares as `sq_missed`, and serves the square again after a fixed delay.

## Interface
- `CLK_HZ`, 25175000: clock frequency; this is the accumulator threshold for a 1-pixel step.
- `VEL_WIDTH`, 10: width of the velocity inputs.
- `H_RES`, 640 / `V_RES`, 480: field size in pixels.
- `SQ_SIZE`, 16: square edge length in pixels.
- `PDL_W`, 16 / `PDL_H`, 96: paddle width and height.
- `PDL_L_X`, 16 / `PDL_R_X`, 608: left x coordinate of the left and right paddles.
- `SERVE_CYCLES`, 25175000: delay from a miss or game start to launch (1 s).
- `clk_0  in  1`: 25.175 MHz clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `sq_xvel  in  VEL_WIDTH`: horizontal speed magnitude, pixels/s.
- `sq_yvel  in  VEL_WIDTH`: vertical speed magnitude, pixels/s.
- `pdl_l_y  in  9`: top y of the left paddle.
- `pdl_r_y  in  9`: top y of the right paddle.
- `game_startup  in  1`: startup menu active.
- `game_over  in  1`: game over screen active.
- `sq_x  out  10`: square top-left x.
- `sq_y  out  9`: square top-left y.
- `paddle_hit  out  1`: one-cycle pulse on paddle contact.
- `hit_y  out  7`: distance from square centre to paddle centre, clamped to `PDL_H/2`; held between hits.
- `sq_missed  out  1`: one-cycle pulse when the square reaches the left or right edge.
- `miss_left  out  1`: side of the last miss (1 = left edge); held between misses.

## Operation
- The block has three states:
  - IDLE: square parked at centre (x = (H_RES−SQ_SIZE)/2 = 312, y = (V_RES−SQ_SIZE)/2 = 232), accumulators cleared.
  - SERVE: counts `SERVE_CYCLES`, square held at centre.
  - PLAY: square moves.
- State transitions, in priority order:
  - `game_startup | game_over` in any state → IDLE on the next edge.
  - IDLE with both inputs low → SERVE.
  - SERVE count done → PLAY.
  - Miss in PLAY → SERVE.
- Direction registers: `dir_x` (1 = right) and `dir_y` (1 = down). Reset values are right and down. Each serve launches away from the side that missed.
- Stepping, per axis: `acc += vel` every PLAY cycle.
  - If `acc ≥ CLK_HZ`, then `acc −= CLK_HZ` and the position steps 1 pixel in the current direction.
  - Accumulator width is `$clog2(CLK_HZ + 2**VEL_WIDTH)`.
  - A step is never made past a boundary; the position saturates.
- Wall bounce:
  - `dir_y` up and `sq_y == 0` → down.
  - `dir_y` down and `sq_y == V_RES−SQ_SIZE` → up.
- Left paddle hit:
  - Condition: `dir_x` left, `sq_x == PDL_L_X+PDL_W`, `sq_y+SQ_SIZE > pdl_l_y`, and `sq_y < pdl_l_y+PDL_H`.
  - Response: `dir_x` ← right, and `paddle_hit` pulses.
- Right paddle hit: same rule using `sq_x+SQ_SIZE == PDL_R_X` and `pdl_r_y`, with `dir_x` ← left.
- Paddle checks apply only when moving toward the paddle. Because the direction flips on contact, each contact produces exactly one pulse.
- `hit_y` = min(|(sq_y+SQ_SIZE/2) − (pdl_y+PDL_H/2)|, PDL_H/2), computed in 10-bit signed arithmetic.
- Miss:
  - Condition: `dir_x` left with `sq_x == 0`, or `dir_x` right with `sq_x == H_RES−SQ_SIZE`.
  - Response: `sq_missed` pulses, `miss_left` is set, position re-centres, and the state moves to SERVE.
- Event priority within one cycle: state override > miss > paddle hit > wall bounce > step.

## Timing
- Reset values:
  - `sq_x` = 312, `sq_y` = 232.
  - `paddle_hit`, `sq_missed`, `hit_y`, `miss_left` = 0.
  - State IDLE, both accumulators 0, counters 0.
- All outputs are registered.
- Hit detection uses the registered position. `paddle_hit` and `hit_y` update in the same cycle, one edge after the contact position appears.
- The velocity mapper updates the velocities one cycle after `paddle_hit`; the next cycle's accumulation uses the new values.
- The maximum speed (2^VEL_WIDTH−1) is far below `CLK_HZ`, so at most one step per axis per cycle.
- The serve delay is exactly `SERVE_CYCLES` edges from SERVE entry to the first PLAY cycle.
- Asserting `rst` during a miss pulse clears that pulse immediately.

## Configuration
- `SQUARE_AIM_EN` defined: on a paddle hit, `dir_y` is set from the contact half. Square centre above the paddle centre → up; otherwise → down.
- `SQUARE_AIM_EN` undefined: a paddle hit leaves `dir_y` unchanged.

## Test plan
- Reset release with `game_startup` = 1 for 100 cycles → `sq_x` = 312, `sq_y` = 232, no pulses.
- `CLK_HZ` = 1000, `SERVE_CYCLES` = 10, `sq_xvel` = 500 → after launch, `sq_x` increments every 2 cycles.
- Square at y = 0 moving up with `sq_yvel` = 400 → `dir_y` flips, y becomes 1 on the next step, never wraps to 511.
- Left paddle at `pdl_l_y` = 200, square reaches x = 32 at y = 200 → single `paddle_hit`, `hit_y` = 40, `dir_x` right. With `SQUARE_AIM_EN`, `dir_y` up.
- Left paddle at `pdl_l_y` = 300, square reaches x = 0 at y = 100 → `sq_missed` one cycle, `miss_left` = 1, re-centre, launch right after `SERVE_CYCLES`.
- `game_over` asserted mid-PLAY → next cycle IDLE at centre. Deassert → SERVE, then PLAY.

Source files
------------

// File: rtl/square_motion.sv
// Pong square motion: integrates pixel/s velocities into position, bounces off walls,
// reports paddle hits and misses, and re-serves. Optional SQUARE_AIM_EN steers dir_y on paddle hits.
module square_motion #(
    parameter int unsigned CLK_HZ       = 25175000,
    parameter int unsigned VEL_WIDTH    = 10,
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned SQ_SIZE      = 16,
    parameter int unsigned PDL_W        = 16,
    parameter int unsigned PDL_H        = 96,
    parameter int unsigned PDL_L_X      = 16,
    parameter int unsigned PDL_R_X      = 608,
    parameter int unsigned SERVE_CYCLES = 25175000
) (
    input  logic                 clk_0,
    input  logic                 rst,
    input  logic [VEL_WIDTH-1:0] sq_xvel,
    input  logic [VEL_WIDTH-1:0] sq_yvel,
    input  logic [8:0]           pdl_l_y,
    input  logic [8:0]           pdl_r_y,
    input  logic                 game_startup,
    input  logic                 game_over,
    output logic [9:0]           sq_x,
    output logic [8:0]           sq_y,
    output logic                 paddle_hit,
    output logic [6:0]           hit_y,
    output logic                 sq_missed,
    output logic                 miss_left
);

    localparam int unsigned ACC_W = $clog2(CLK_HZ + 2**VEL_WIDTH);
    localparam int unsigned CNT_W = $clog2(SERVE_CYCLES + 1);

    localparam logic [9:0]       X_MAX    = 10'(H_RES - SQ_SIZE);
    localparam logic [9:0]       X_CTR    = 10'((H_RES - SQ_SIZE) / 2);
    localparam logic [8:0]       Y_MAX    = 9'(V_RES - SQ_SIZE);
    localparam logic [8:0]       Y_CTR    = 9'((V_RES - SQ_SIZE) / 2);
    localparam logic [9:0]       X_PDL_L  = 10'(PDL_L_X + PDL_W);
    localparam logic [9:0]       X_PDL_R  = 10'(PDL_R_X - SQ_SIZE);
    localparam logic [9:0]       HALF_PDL = 10'(PDL_H / 2);
    localparam logic [ACC_W-1:0] ACC_TOP  = ACC_W'(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY} state_t;

    state_t           state, state_nxt;
    logic             dir_x, dir_x_nxt, dir_y, dir_y_nxt;
    logic [ACC_W-1:0] acc_x, acc_x_nxt, acc_y, acc_y_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [9:0]       sq_x_nxt;
    logic [8:0]       sq_y_nxt;
    logic             paddle_hit_nxt, sq_missed_nxt, miss_left_nxt;
    logic [6:0]       hit_y_nxt;

    logic [9:0]       y_ext, pdl_sel, diff, mag;
    logic             hit_l, hit_r, miss;
    logic [ACC_W-1:0] sum_x, sum_y;
    logic             step_x, step_y;

    // Contact, miss and accumulator-overflow detection from the registered position
    always_comb begin
        y_ext   = {1'b0, sq_y};
        hit_l   = !dir_x && (sq_x == X_PDL_L)
                  && (y_ext + 10'(SQ_SIZE) > {1'b0, pdl_l_y})
                  && (y_ext < {1'b0, pdl_l_y} + 10'(PDL_H));
        hit_r   = dir_x && (sq_x == X_PDL_R)
                  && (y_ext + 10'(SQ_SIZE) > {1'b0, pdl_r_y})
                  && (y_ext < {1'b0, pdl_r_y} + 10'(PDL_H));
        pdl_sel = hit_l ? {1'b0, pdl_l_y} : {1'b0, pdl_r_y};
        diff    = (y_ext + 10'(SQ_SIZE / 2)) - (pdl_sel + HALF_PDL);
        mag     = diff[9] ? (~diff + 10'd1) : diff;
        miss    = (!dir_x && (sq_x == 10'd0)) || (dir_x && (sq_x == X_MAX));
        sum_x   = acc_x + ACC_W'(sq_xvel);
        sum_y   = acc_y + ACC_W'(sq_yvel);
        step_x  = (sum_x >= ACC_TOP);
        step_y  = (sum_y >= ACC_TOP);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        dir_x_nxt      = dir_x;
        dir_y_nxt      = dir_y;
        acc_x_nxt      = acc_x;
        acc_y_nxt      = acc_y;
        cnt_nxt        = cnt;
        sq_x_nxt       = sq_x;
        sq_y_nxt       = sq_y;
        paddle_hit_nxt = 1'b0;
        sq_missed_nxt  = 1'b0;
        hit_y_nxt      = hit_y;
        miss_left_nxt  = miss_left;

        if (game_startup || game_over) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            acc_x_nxt = '0;
            acc_y_nxt = '0;
            sq_x_nxt  = X_CTR;
            sq_y_nxt  = Y_CTR;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SERVE;
                    cnt_nxt   = '0;
                    acc_x_nxt = '0;
                    acc_y_nxt = '0;
                    sq_x_nxt  = X_CTR;
                    sq_y_nxt  = Y_CTR;
                end
                SERVE: begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = PLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                PLAY: begin
                    if (miss) begin
                        state_nxt     = SERVE;
                        cnt_nxt       = '0;
                        sq_missed_nxt = 1'b1;
                        miss_left_nxt = !dir_x;
                        dir_x_nxt     = !dir_x;
                        acc_x_nxt     = '0;
                        acc_y_nxt     = '0;
                        sq_x_nxt      = X_CTR;
                        sq_y_nxt      = Y_CTR;
                    end else begin
                        if (!dir_y && (sq_y == 9'd0)) begin
                            dir_y_nxt = 1'b1;
                        end else if (dir_y && (sq_y == Y_MAX)) begin
                            dir_y_nxt = 1'b0;
                        end
                        // Paddle response overrides the wall bounce on the same cycle
                        if (hit_l || hit_r) begin
                            dir_x_nxt      = hit_l;
                            paddle_hit_nxt = 1'b1;
                            hit_y_nxt      = (mag > HALF_PDL) ? HALF_PDL[6:0] : mag[6:0];
`ifdef SQUARE_AIM_EN
                            dir_y_nxt      = !diff[9];
`endif
                        end
                        acc_x_nxt = step_x ? (sum_x - ACC_TOP) : sum_x;
                        acc_y_nxt = step_y ? (sum_y - ACC_TOP) : sum_y;
                        // Steps saturate at the field edges
                        if (step_x) begin
                            if (dir_x_nxt && (sq_x != X_MAX)) begin
                                sq_x_nxt = sq_x + 10'd1;
                            end else if (!dir_x_nxt && (sq_x != 10'd0)) begin
                                sq_x_nxt = sq_x - 10'd1;
                            end
                        end
                        if (step_y) begin
                            if (dir_y_nxt && (sq_y != Y_MAX)) begin
                                sq_y_nxt = sq_y + 9'd1;
                            end else if (!dir_y_nxt && (sq_y != 9'd0)) begin
                                sq_y_nxt = sq_y - 9'd1;
                            end
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            acc_x      <= '0;
            acc_y      <= '0;
            cnt        <= '0;
            sq_x       <= X_CTR;
            sq_y       <= Y_CTR;
            paddle_hit <= 1'b0;
            sq_missed  <= 1'b0;
            hit_y      <= 7'd0;
            miss_left  <= 1'b0;
        end else begin
            state      <= state_nxt;
            dir_x      <= dir_x_nxt;
            dir_y      <= dir_y_nxt;
            acc_x      <= acc_x_nxt;
            acc_y      <= acc_y_nxt;
            cnt        <= cnt_nxt;
            sq_x       <= sq_x_nxt;
            sq_y       <= sq_y_nxt;
            paddle_hit <= paddle_hit_nxt;
            sq_missed  <= sq_missed_nxt;
            hit_y      <= hit_y_nxt;
            miss_left  <= miss_left_nxt;
        end
    end

endmodule

// File: tb/tb_square_motion.sv
// Self-checking bench for square_motion against a pixel-level behavioural model of the Pong square.
`timescale 1ns/1ps
module tb_square_motion;

    localparam int CLK_HZ  = 1000;
    localparam int SERVE   = 10;
    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int SQ      = 16;
    localparam int PDL_W   = 16;
    localparam int PDL_H   = 96;
    localparam int PDL_L_X = 16;
    localparam int PDL_R_X = 608;
    localparam int XMAX    = H_RES - SQ;
    localparam int YMAX    = V_RES - SQ;
    localparam int XC      = XMAX / 2;
    localparam int YC      = YMAX / 2;

    logic       clk_0 = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sq_xvel = 10'd0;
    logic [9:0] sq_yvel = 10'd0;
    logic [8:0] pdl_l_y = 9'd0;
    logic [8:0] pdl_r_y = 9'd0;
    logic       game_startup = 1'b1;
    logic       game_over = 1'b0;
    logic [9:0] sq_x;
    logic [8:0] sq_y;
    logic       paddle_hit;
    logic [6:0] hit_y;
    logic       sq_missed;
    logic       miss_left;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: position, +1/-1 directions, sub-pixel budgets, edges left before play
    int m_x = XC, m_y = YC, m_dx = 1, m_dy = 1, m_ax = 0, m_ay = 0, m_wait = 0, m_hy = 0;
    bit m_idle = 1'b1, m_hit = 1'b0, m_miss = 1'b0, m_left = 1'b0;

    square_motion #(
        .CLK_HZ(CLK_HZ), .VEL_WIDTH(10), .H_RES(H_RES), .V_RES(V_RES), .SQ_SIZE(SQ),
        .PDL_W(PDL_W), .PDL_H(PDL_H), .PDL_L_X(PDL_L_X), .PDL_R_X(PDL_R_X), .SERVE_CYCLES(SERVE)
    ) dut (
        .clk_0(clk_0), .rst(rst), .sq_xvel(sq_xvel), .sq_yvel(sq_yvel),
        .pdl_l_y(pdl_l_y), .pdl_r_y(pdl_r_y), .game_startup(game_startup), .game_over(game_over),
        .sq_x(sq_x), .sq_y(sq_y), .paddle_hit(paddle_hit), .hit_y(hit_y),
        .sq_missed(sq_missed), .miss_left(miss_left)
    );

    always #5 clk_0 = ~clk_0;

    function automatic logic [28:0] dut_vec();
        return {sq_x, sq_y, paddle_hit, hit_y, sq_missed, miss_left};
    endfunction

    function automatic logic [28:0] model_vec();
        return {10'(m_x), 9'(m_y), m_hit, 7'(m_hy), m_miss, m_left};
    endfunction

    function automatic string show();
        return $sformatf("got x=%0d y=%0d hit=%b hy=%0d miss=%b ml=%b, want x=%0d y=%0d hit=%b hy=%0d miss=%b ml=%b",
                         sq_x, sq_y, paddle_hit, hit_y, sq_missed, miss_left,
                         m_x, m_y, m_hit, m_hy, m_miss, m_left);
    endfunction

    task automatic model_reset();
        m_x = XC; m_y = YC; m_dx = 1; m_dy = 1; m_ax = 0; m_ay = 0; m_wait = 0; m_hy = 0;
        m_idle = 1'b1; m_hit = 1'b0; m_miss = 1'b0; m_left = 1'b0;
    endtask

    task automatic model_play();
        int  py, d;
        bit  hl, hr;
        if ((m_dx < 0 && m_x == 0) || (m_dx > 0 && m_x == XMAX)) begin
            m_miss = 1'b1;
            m_left = (m_dx < 0);
            m_dx   = m_left ? 1 : -1;
            m_x = XC; m_y = YC; m_ax = 0; m_ay = 0;
            m_wait = SERVE;
        end else begin
            hl = (m_dx < 0) && (m_x == PDL_L_X + PDL_W)
                 && (m_y + SQ > int'(pdl_l_y)) && (m_y < int'(pdl_l_y) + PDL_H);
            hr = (m_dx > 0) && (m_x + SQ == PDL_R_X)
                 && (m_y + SQ > int'(pdl_r_y)) && (m_y < int'(pdl_r_y) + PDL_H);
            if (m_dy < 0 && m_y == 0) m_dy = 1;
            else if (m_dy > 0 && m_y == YMAX) m_dy = -1;
            if (hl || hr) begin
                py = hl ? int'(pdl_l_y) : int'(pdl_r_y);
                d  = (m_y + SQ / 2) - (py + PDL_H / 2);
                if (d < 0) d = -d;
                m_hy  = (d > PDL_H / 2) ? PDL_H / 2 : d;
                m_hit = 1'b1;
                m_dx  = -m_dx;
`ifdef SQUARE_AIM_EN
                m_dy = (m_y + SQ / 2 < py + PDL_H / 2) ? -1 : 1;
`endif
            end
            m_ax += int'(sq_xvel);
            if (m_ax >= CLK_HZ) begin
                m_ax -= CLK_HZ;
                if (m_x + m_dx >= 0 && m_x + m_dx <= XMAX) m_x += m_dx;
            end
            m_ay += int'(sq_yvel);
            if (m_ay >= CLK_HZ) begin
                m_ay -= CLK_HZ;
                if (m_y + m_dy >= 0 && m_y + m_dy <= YMAX) m_y += m_dy;
            end
        end
    endtask

    task automatic model_update();
        m_hit  = 1'b0;
        m_miss = 1'b0;
        if (rst) begin
            model_reset();
        end else if (game_startup || game_over) begin
            m_idle = 1'b1; m_wait = 0; m_x = XC; m_y = YC; m_ax = 0; m_ay = 0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            m_wait = SERVE;
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            model_play();
        end
    endtask

    // One clock: model advances on the edge, sampling happens on the following falling edge
    task automatic cycle();
        @(posedge clk_0);
        model_update();
        @(negedge clk_0);
    endtask

    task automatic test_reset();
        rst = 1'b1; game_startup = 1'b1; game_over = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL reset_track t=%0t %s", $time, show());
            end
        end
        n_cmp++;
        if (sq_x !== 10'd312 || sq_y !== 9'd232 || paddle_hit !== 1'b0 || sq_missed !== 1'b0) begin
            n_fail++; $display("FAIL reset_park x=%0d y=%0d hit=%b miss=%b, want 312 232 0 0",
                               sq_x, sq_y, paddle_hit, sq_missed);
        end
    endtask

    task automatic test_step_rate();
        int last = -1, changes = 0;
        logic [9:0] prev;
        sq_xvel = 10'd500; sq_yvel = 10'd0; pdl_l_y = 9'd0; pdl_r_y = 9'd0;
        game_startup = 1'b0;
        prev = sq_x;
        for (int i = 0; i < 80; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL step_track t=%0t %s", $time, show());
            end
            if (sq_x !== prev) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (i - last != 2) begin
                        n_fail++; $display("FAIL step_interval got %0d cycles want 2", i - last);
                    end
                end
                last = i; prev = sq_x; changes++;
            end
        end
        n_cmp++;
        if (changes < 10 || sq_x <= 10'd312) begin
            n_fail++; $display("FAIL step_progress changes=%0d x=%0d, want >=10 steps rightward", changes, sq_x);
        end
    endtask

    task automatic test_right_miss();
        bit found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL rmiss_track t=%0t %s", $time, show());
            end
            if (sq_missed) found = 1'b1;
        end
        n_cmp++;
        if (!found || miss_left !== 1'b0 || sq_x !== 10'd312) begin
            n_fail++; $display("FAIL right_miss found=%b ml=%b x=%0d, want 1 0 312", found, miss_left, sq_x);
        end
    endtask

    task automatic test_paddle_hit();
        int hits = 0, first = -1, hy = 0, x_at = 0;
        logic [8:0] y0;
        pdl_l_y = 9'd232; sq_xvel = 10'd999; sq_yvel = 10'd0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL hit_track t=%0t %s", $time, show());
            end
            if (paddle_hit) begin
                hits++;
                if (first < 0) begin first = i; hy = int'(hit_y); x_at = int'(sq_x); end
            end
            if (first >= 0 && i >= first + 40) break;
        end
        n_cmp++;
        if (hits != 1 || hy != 40) begin
            n_fail++; $display("FAIL paddle_hit pulses=%0d hit_y=%0d, want 1 40", hits, hy);
        end
        n_cmp++;
        if (int'(sq_x) <= x_at) begin
            n_fail++; $display("FAIL hit_dir_x x=%0d after hit at %0d, want moving right", sq_x, x_at);
        end
        y0 = sq_y;
        sq_yvel = 10'd999;
        repeat (10) cycle();
        sq_yvel = 10'd0;
        n_cmp++;
`ifdef SQUARE_AIM_EN
        if (sq_y >= y0) begin
            n_fail++; $display("FAIL hit_aim y=%0d from %0d, want moving up", sq_y, y0);
        end
`else
        if (sq_y <= y0) begin
            n_fail++; $display("FAIL hit_noaim y=%0d from %0d, want moving down", sq_y, y0);
        end
`endif
    endtask

    task automatic test_left_miss();
        bit found = 1'b0;
        int wait_n = -1;
        pdl_l_y = 9'd300; pdl_r_y = 9'd0; sq_xvel = 10'd999; sq_yvel = 10'd0;
        for (int i = 0; i < 2500 && !found; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL lmiss_track t=%0t %s", $time, show());
            end
            if (sq_missed && miss_left) found = 1'b1;
        end
        n_cmp++;
        if (!found || sq_x !== 10'd312 || sq_y !== 9'd232) begin
            n_fail++; $display("FAIL left_miss found=%b x=%0d y=%0d, want 1 312 232", found, sq_x, sq_y);
        end
        for (int k = 1; k <= 100; k++) begin
            cycle();
            if (sq_x !== 10'd312) begin wait_n = k; break; end
        end
        // SERVE edges of delay, then two 999 px/s accumulations before the first pixel
        n_cmp++;
        if (wait_n != SERVE + 2 || sq_x !== 10'd313) begin
            n_fail++; $display("FAIL relaunch cycles=%0d x=%0d, want %0d 313", wait_n, sq_x, SERVE + 2);
        end
    endtask

    task automatic test_wall();
        bit seen_zero = 1'b0, done = 1'b0;
        game_over = 1'b1;
        cycle();
        game_over = 1'b0; sq_xvel = 10'd0; sq_yvel = 10'd400;
        for (int i = 0; i < 4000 && !done; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL wall_track t=%0t %s", $time, show());
            end
            n_cmp++;
            if (int'(sq_y) > YMAX) begin
                n_fail++; $display("FAIL wall_range y=%0d, want <= %0d", sq_y, YMAX);
            end
            if (seen_zero && sq_y !== 9'd0) begin
                n_cmp++;
                if (sq_y !== 9'd1) begin
                    n_fail++; $display("FAIL wall_bounce y=%0d after 0, want 1", sq_y);
                end
                done = 1'b1;
            end
            if (sq_y === 9'd0) seen_zero = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_fail++; $display("FAIL wall_timeout seen_zero=%b, want bounce off top", seen_zero);
        end
    endtask

    task automatic test_game_over();
        int wait_n = -1;
        sq_xvel = 10'd700;
        repeat (20) cycle();
        game_over = 1'b1;
        cycle();
        n_cmp++;
        if (sq_x !== 10'd312 || sq_y !== 9'd232) begin
            n_fail++; $display("FAIL over_centre x=%0d y=%0d, want 312 232", sq_x, sq_y);
        end
        repeat (2) cycle();
        game_over = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL over_track t=%0t %s", $time, show());
            end
            if (sq_x !== 10'd312) begin wait_n = k; break; end
        end
        // One edge into SERVE, SERVE edges of delay, two 700 px/s accumulations
        n_cmp++;
        if (wait_n != SERVE + 3) begin
            n_fail++; $display("FAIL over_relaunch cycles=%0d, want %0d", wait_n, SERVE + 3);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                sq_xvel   = 10'($urandom_range(999, 0));
                sq_yvel   = 10'($urandom_range(999, 0));
                pdl_l_y   = 9'($urandom_range(384, 0));
                pdl_r_y   = 9'($urandom_range(384, 0));
                game_over = ($urandom_range(15, 0) == 0);
            end else begin
                game_over = 1'b0;
            end
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random_track t=%0t %s", $time, show());
            end
        end
    endtask

    task automatic test_rst_during_miss();
        bit found = 1'b0;
        game_over = 1'b1;
        cycle();
        game_over = 1'b0; pdl_l_y = 9'd400; pdl_r_y = 9'd400; sq_xvel = 10'd999; sq_yvel = 10'd0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL rstmiss_track t=%0t %s", $time, show());
            end
            if (sq_missed) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++; $display("FAIL rstmiss_timeout got no miss pulse, want one");
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sq_missed !== 1'b0 || sq_x !== 10'd312 || miss_left !== 1'b0) begin
            n_fail++; $display("FAIL rst_clears_miss miss=%b x=%0d ml=%b, want 0 312 0", sq_missed, sq_x, miss_left);
        end
        cycle();
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL rst_hold t=%0t %s", $time, show());
        end
        rst = 1'b0;
        repeat (5) cycle();
    endtask

    initial begin
        test_reset();
        test_step_rate();
        test_right_miss();
        test_paddle_hit();
        test_left_miss();
        test_wall();
        test_game_over();
        test_random();
        test_rst_during_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
